// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned STRB_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Write-side payload presented to the memory macro alongside the index.
  typedef struct packed {
    logic              we;
    logic [STRB_W-1:0] strb;
    logic [XLEN-1:0]   wdata;
  } mem_wr_t;

  // Select the 32-bit instruction word out of a fetched doubleword.
  function automatic logic [ILEN-1:0] pick_half(input logic [XLEN-1:0] dword,
                                                input logic            hi);
    return hi ? dword[XLEN-1:ILEN] : dword[ILEN-1:0];
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles; at_max forces an IF win.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == CNT_W'(STARVE_MAX));
  assign o_at_max = w_at_max;

  // Clear wins over increment; hold once saturated.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !w_at_max) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64-bit synchronous memory between fetch (IF) and
// load/store (DM); DM has priority, a starvation guard bounds the IF wait.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_AW     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [ILEN-1:0]   if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [STRB_W-1:0] dm_strb,
  input  logic [XLEN-1:0]   dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_strb,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  logic        w_at_max;
  logic        w_force_if;
  logic        w_if_gnt;
  logic        w_dm_gnt;
  logic        w_cnt_inc;
  logic        w_cnt_clr;
  owner_e      r_owner;
  owner_e      w_owner_nxt;
  logic        r_if_hi;
  logic        w_if_hi_nxt;
  logic        r_dm_store;
  logic        w_dm_store_nxt;
  mem_wr_t     w_wr;
  logic [MEM_AW-1:0] w_mem_addr;
  logic        w_unused;

  // Byte-offset and above-memory address bits never reach the macro.
  assign w_unused = ^{if_addr[XLEN-1:MEM_AW+3], if_addr[1:0],
                      dm_addr[XLEN-1:MEM_AW+3], dm_addr[2:0]};

  assign w_force_if = if_req && w_at_max;

  // Fixed priority with starvation override; nothing granted in reset.
  always_comb begin
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    if (rst) begin
      if (w_force_if) begin
        w_if_gnt = 1'b1;
      end else if (dm_req) begin
        w_dm_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end
    end
  end

  assign if_gnt = w_if_gnt;
  assign dm_gnt = w_dm_gnt;

  assign w_cnt_inc = if_req && !w_if_gnt;
  assign w_cnt_clr = !if_req || w_if_gnt;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_cnt_clr),
    .o_at_max (w_at_max)
  );

  // Memory command mux; the granted requester drives the macro this cycle.
  always_comb begin
    mem_en     = 1'b0;
    w_mem_addr = '0;
    w_wr       = '0;
    if (w_dm_gnt) begin
      mem_en     = 1'b1;
      w_mem_addr = dm_addr[MEM_AW+2:3];
      w_wr.we    = dm_we;
      w_wr.strb  = dm_we ? dm_strb : '0;
      w_wr.wdata = dm_wdata;
    end else if (w_if_gnt) begin
      mem_en     = 1'b1;
      w_mem_addr = if_addr[MEM_AW+2:3];
    end
  end

  assign mem_addr  = w_mem_addr;
  assign mem_we    = w_wr.we;
  assign mem_strb  = w_wr.strb;
  assign mem_wdata = w_wr.wdata;

  // Owner of the single outstanding response, plus the context it needs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner    <= OWN_NONE;
      r_if_hi    <= 1'b0;
      r_dm_store <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_if_hi    <= w_if_hi_nxt;
      r_dm_store <= w_dm_store_nxt;
    end
  end

  always_comb begin
    w_owner_nxt    = OWN_NONE;
    w_if_hi_nxt    = r_if_hi;
    w_dm_store_nxt = r_dm_store;
    if (w_dm_gnt) begin
      w_owner_nxt    = OWN_DM;
      w_dm_store_nxt = dm_we;
    end else if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
      w_if_hi_nxt = if_addr[2];
    end
  end

  // Response routing: memory data arrives one cycle after the grant.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    case (r_owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = pick_half(mem_rdata, r_if_hi);
      end
      OWN_DM: begin
        dm_rvalid = 1'b1;
        dm_rdata  = r_dm_store ? '0 : mem_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 64-bit-wide synchronous memory between two requesters in the RV64I core: instruction fetch (IF) and the load/store unit (DM).
- Sits between the core's fetch and memory stages and a unified memory macro, replacing the separate im/dm arrays.
- Arbitrates each cycle, tracks the one outstanding response and routes it back to the owning requester.
- DM has priority over IF; a starvation guard bounds how long IF can wait.

Parameters:
- MEM_AW, 16, memory index width in doublewords; memory holds 2^MEM_AW x 64 bits.
- STARVE_MAX, 4, consecutive denied IF-request cycles after which IF is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  64  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  instruction word.
- dm_req  in  1  data request; held until granted.
- dm_we  in  1  1 = store, 0 = load.
- dm_strb  in  8  byte-write strobes; ignored for loads.
- dm_addr  in  64  data byte address; bits [2:0] ignored.
- dm_wdata  in  64  store data, already lane-aligned.
- dm_gnt  out  1  data granted this cycle (combinational).
- dm_rvalid  out  1  load data valid, or store acknowledge.
- dm_rdata  out  64  load doubleword; 0 on store acknowledge.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_strb  out  8  memory byte strobes.
- mem_addr  out  MEM_AW  doubleword index.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid the cycle after an enabled read.

Behaviour:
- Reset (rst=0, asynchronous):
  - owner register = NONE, starve counter = 0, latched half-select = 0.
  - if_rvalid = dm_rvalid = 0, if_rdata = dm_rdata = 0.
  - Grants and mem_en are forced to 0 while rst is low.
- Arbitration, combinational each cycle:
  - force_if = if_req && (starve_cnt == STARVE_MAX).
  - If force_if, IF is granted.
  - Otherwise, if dm_req, DM is granted.
  - Otherwise, if if_req, IF is granted.
  - At most one grant per cycle; a grant implies mem_en = 1 in the same cycle.
- Memory drive:
  - IF grant: mem_addr = if_addr[MEM_AW+2:3], mem_we = 0, mem_strb = 0.
  - DM grant: mem_addr = dm_addr[MEM_AW+2:3], mem_we = dm_we, mem_strb = dm_we ? dm_strb : 0, mem_wdata = dm_wdata.
  - Upper address bits are dropped (address wraps modulo memory size).
- Latency: a response comes exactly 1 cycle after a grant.
  - The owner register records IF, DM or NONE at the clock edge.
  - IF response: if_rvalid = 1, if_rdata = mem_rdata[63:32] if the latched if_addr[2] = 1, else mem_rdata[31:0].
  - DM load response: dm_rvalid = 1, dm_rdata = mem_rdata.
  - DM store response: dm_rvalid = 1, dm_rdata = 0.
  - rvalid is a 1-cycle pulse; requesters must accept it (no back-pressure).
- Throughput: one grant per cycle. Back-to-back grants are allowed; a response for grant N coexists with the issue of grant N+1.
- Starve counter:
  - Increments (saturating at STARVE_MAX) in each cycle where if_req = 1 and IF is not granted.
  - Clears on an IF grant, or when if_req = 0.
- Simultaneous requests: both high with counter < STARVE_MAX grants DM. IF is therefore granted no later than the (STARVE_MAX+1)-th cycle of continuous contention.
- Idle: no request gives mem_en = 0 and owner = NONE next cycle; no rvalid.
- Reset mid-operation: an outstanding response is discarded; no rvalid is produced after reset releases until a new grant.
- Requests are not checked for alignment; misaligned dm_addr uses the doubleword containing it.

Decomposition:
- Shared package mem_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_IF, OWN_DM}.
  - XLEN = 64, ILEN = 32, STRB_W = 8.
- One sub-module, arb_starve_cnt: saturating counter with inc/clr inputs and an at_max output, parameterised by STARVE_MAX.

Test Plan:
- Reset: hold rst=0 with both reqs high -> no grants, mem_en=0, all rvalid/rdata 0. Release -> DM granted first cycle.
- Solo fetch: if_req, if_addr=0x0000001C, mem[3]=0x1122334455667788 -> if_gnt, mem_addr=3; next cycle if_rvalid=1, if_rdata=0x11223344. With if_addr=0x18 -> if_rdata=0x55667788.
- Store then load: dm_we=1, addr=0x40, strb=0x0F, wdata=0xAAAAAAAA_DEADBEEF over mem[8]=0 -> dm_rvalid next cycle with dm_rdata=0. Following load of 0x40 -> dm_rdata=0x00000000_DEADBEEF.
- Contention: both reqs continuously high, STARVE_MAX=4 -> DM granted cycles 0-3, IF granted cycle 4, DM cycles 5-8, IF cycle 9. Responses arrive in grant order with correct routing.
- Back-to-back: DM loads to 0x0, 0x8, 0x10 on consecutive cycles -> dm_rvalid high for 3 consecutive cycles with the matching data.
- Reset mid-op: assert rst=0 in the cycle after a DM grant -> dm_rvalid stays 0 through and after reset release.
